// File: rtl/multicycle_controls_if.sv
// Control bundle between the multicycle controller (master) and its datapath (slave).
// The controller drives every strobe; the datapath supplies the instruction and status.
interface multicycle_controls_if #(
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 16
);
  logic [31:0]        instr;
  logic               zero;
  logic               mem_ready;
  logic               IRWrite;
  logic               PCWrite;
  logic               Reg2Loc;
  logic               UncondBr;
  logic               BrTaken;
  logic               RegWrite;
  logic               MemRead;
  logic               MemWrite;
  logic               ALUSrc;
  logic               MemToReg;
  logic [ALUOP_W-1:0] ALUOp;
  logic               trap;
  logic               mem_err;
  logic [CNT_W-1:0]   retired;

  modport master (
    input  instr, zero, mem_ready,
    output IRWrite, PCWrite, Reg2Loc, UncondBr, BrTaken, RegWrite,
           MemRead, MemWrite, ALUSrc, MemToReg, ALUOp, trap, mem_err, retired
  );

  modport slave (
    output instr, zero, mem_ready,
    input  IRWrite, PCWrite, Reg2Loc, UncondBr, BrTaken, RegWrite,
           MemRead, MemWrite, ALUSrc, MemToReg, ALUOp, trap, mem_err, retired
  );
endinterface

// File: rtl/multicycle_controls.sv
// Moore-style control FSM for a small multicycle LEGv8 datapath, with a bounded
// memory wait, a sticky trap state and a saturating retired-instruction counter.
module multicycle_controls #(
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int EN_CBNZ     = 1,
  parameter int CNT_W       = 16
) (
  input  logic clk,
  input  logic reset_n,
  multicycle_controls_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_ILL, C_ADD, C_SUB, C_ADDI, C_LDUR, C_STUR, C_B, C_CBZ, C_CBNZ
  } instrClass_t;

  localparam int WAIT_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int TO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

  localparam logic [ALUOP_W-1:0] ALU_PASS = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(3'b011);

  state_t             r_state;
  state_t             w_nextState;
  instrClass_t        r_class;
  instrClass_t        w_decClass;
  logic [WAIT_W-1:0]  r_wait;
  logic [CNT_W-1:0]   r_retired;
  logic               r_memErr;
  logic               w_timeout;
  logic               w_unusedInstr;

  logic               w_irWrite, w_pcWrite, w_reg2Loc, w_uncondBr, w_brTaken;
  logic               w_regWrite, w_memRead, w_memWrite, w_aluSrc, w_memToReg;
  logic               w_trap;
  logic [ALUOP_W-1:0] w_aluOp;

  assign w_unusedInstr = ^bus.instr[20:0];

  always_comb begin
    w_decClass = C_ILL;
    casez (bus.instr[31:21])
      11'b10001011000: w_decClass = C_ADD;
      11'b11001011000: w_decClass = C_SUB;
      11'b1001000100?: w_decClass = C_ADDI;
      11'b11111000010: w_decClass = C_LDUR;
      11'b11111000000: w_decClass = C_STUR;
      11'b000101?????: w_decClass = C_B;
      11'b10110100???: w_decClass = C_CBZ;
      11'b10110101???: w_decClass = (EN_CBNZ != 0) ? C_CBNZ : C_ILL;
      default:         w_decClass = C_ILL;
    endcase
  end

  // Timeout fires on the last permitted MEM cycle; a ready strobe that same cycle still completes.
  assign w_timeout = (MEM_TIMEOUT > 0) && (r_state == S_MEM) && !bus.mem_ready &&
                     (r_wait == WAIT_W'(TO_LAST));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_FETCH:  w_nextState = S_DECODE;
      S_DECODE: begin
        if (w_decClass == C_ILL)    w_nextState = S_TRAP;
        else if (w_decClass == C_B) w_nextState = S_FETCH;
        else                        w_nextState = S_EXEC;
      end
      S_EXEC: begin
        case (r_class)
          C_ADD, C_SUB, C_ADDI: w_nextState = S_WB;
          C_LDUR, C_STUR:       w_nextState = S_MEM;
          default:              w_nextState = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (bus.mem_ready)  w_nextState = (r_class == C_LDUR) ? S_WB : S_FETCH;
        else if (w_timeout) w_nextState = S_TRAP;
        else                w_nextState = S_MEM;
      end
      S_WB:    w_nextState = S_FETCH;
      S_TRAP:  w_nextState = S_TRAP;
      default: w_nextState = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_class   <= C_ILL;
      r_wait    <= '0;
      r_retired <= '0;
      r_memErr  <= 1'b0;
    end else begin
      if (r_state == S_DECODE) r_class <= w_decClass;
      if (r_state != S_MEM) begin
        r_wait <= '0;
      end else if (!bus.mem_ready && (r_wait != '1)) begin
        r_wait <= r_wait + 1'b1;
      end
      if (w_timeout) r_memErr <= 1'b1;
      if (w_pcWrite && (r_retired != '1)) r_retired <= r_retired + 1'b1;
    end
  end

  always_comb begin
    w_irWrite  = 1'b0;
    w_pcWrite  = 1'b0;
    w_reg2Loc  = 1'b0;
    w_uncondBr = 1'b0;
    w_brTaken  = 1'b0;
    w_regWrite = 1'b0;
    w_memRead  = 1'b0;
    w_memWrite = 1'b0;
    w_aluSrc   = 1'b0;
    w_memToReg = 1'b0;
    w_trap     = 1'b0;
    w_aluOp    = ALU_PASS;
    case (r_state)
      S_FETCH: w_irWrite = 1'b1;
      // The class is not latched yet, so B resolves from the live instruction.
      S_DECODE: begin
        if (w_decClass == C_B) begin
          w_pcWrite  = 1'b1;
          w_brTaken  = 1'b1;
          w_uncondBr = 1'b1;
        end
      end
      S_EXEC: begin
        case (r_class)
          C_ADD: begin
            w_reg2Loc = 1'b1;
            w_aluOp   = ALU_ADD;
          end
          C_SUB: begin
            w_reg2Loc = 1'b1;
            w_aluOp   = ALU_SUB;
          end
          C_ADDI, C_LDUR, C_STUR: begin
            w_aluSrc = 1'b1;
            w_aluOp  = ALU_ADD;
          end
          C_CBZ: begin
            w_pcWrite = 1'b1;
            w_brTaken = bus.zero;
          end
          C_CBNZ: begin
            w_pcWrite = 1'b1;
            w_brTaken = ~bus.zero;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        w_memRead  = (r_class == C_LDUR);
        w_memWrite = (r_class == C_STUR);
        w_pcWrite  = (r_class == C_STUR) && bus.mem_ready;
      end
      S_WB: begin
        w_regWrite = 1'b1;
        w_pcWrite  = 1'b1;
        w_memToReg = (r_class == C_LDUR);
      end
      S_TRAP:  w_trap = 1'b1;
      default: ;
    endcase
  end

  // Holding reset silences every strobe immediately, even mid memory access.
  assign bus.IRWrite  = reset_n & w_irWrite;
  assign bus.PCWrite  = reset_n & w_pcWrite;
  assign bus.Reg2Loc  = reset_n & w_reg2Loc;
  assign bus.UncondBr = reset_n & w_uncondBr;
  assign bus.BrTaken  = reset_n & w_brTaken;
  assign bus.RegWrite = reset_n & w_regWrite;
  assign bus.MemRead  = reset_n & w_memRead;
  assign bus.MemWrite = reset_n & w_memWrite;
  assign bus.ALUSrc   = reset_n & w_aluSrc;
  assign bus.MemToReg = reset_n & w_memToReg;
  assign bus.ALUOp    = reset_n ? w_aluOp : '0;
  assign bus.trap     = reset_n & w_trap;
  assign bus.mem_err  = r_memErr;
  assign bus.retired  = r_retired;

endmodule

// File: doc/multicycle_controls.md
MULTICYCLE_CONTROLS -- requirements
Module: multicycle_controls

Interface
REQ-001 The block SHALL have parameter ALUOP_W, default 3, giving the ALUOp width; it SHALL be at least 3.
REQ-002 The block SHALL have parameter MEM_TIMEOUT, default 15, giving the maximum cycles spent in MEM; 0 SHALL disable the timeout.
REQ-003 The block SHALL have parameter EN_CBNZ, default 1; when it is 1, CBNZ is legal, and when it is 0, CBNZ decodes as illegal.
REQ-004 The block SHALL have parameter CNT_W, default 16, giving the retired-instruction counter width.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 reset_n  input  1  reset; synchronous and active-low.
REQ-007 instr  input  32  instruction register contents, valid from DECODE onward.
REQ-008 zero  input  1  ALU zero flag, sampled in EXEC.
REQ-009 mem_ready  input  1  data-memory completion strobe.
REQ-010 Outputs: IRWrite, PCWrite, Reg2Loc, UncondBr, BrTaken, RegWrite, MemRead, MemWrite, ALUSrc, MemToReg; each is 1 bit.
REQ-011 ALUOp  output  ALUOP_W  ALU function: 000 = pass B, 010 = add, 011 = sub, zero-extended to the full width.
REQ-012 trap  output  1  sticky illegal-opcode or memory-timeout indication.
REQ-013 mem_err  output  1  sticky; set only when a memory timeout causes the trap.
REQ-014 retired  output  CNT_W  count of completed instructions.

Function
REQ-015 Decode SHALL use instr[31:21] with don't-care bits:
- ADD = 10001011000
- SUB = 11001011000
- ADDI = 1001000100x
- LDUR = 11111000010
- STUR = 11111000000
- B = 000101xxxxx
- CBZ = 10110100xxx
- CBNZ = 10110101xxx
- any other value is illegal.
REQ-016 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB, TRAP; outputs are Moore, decoded from the state, the latched class and zero; every output not listed for a state SHALL be 0, and no output is ever X.
REQ-017 FETCH: IRWrite=1; the next state SHALL be DECODE.
REQ-018 DECODE: the instruction class SHALL be latched.
- Illegal: the next state SHALL be TRAP.
- B: PCWrite=1, BrTaken=1, UncondBr=1; the next state SHALL be FETCH.
- Any other legal class: the next state SHALL be EXEC.
REQ-019 EXEC, ADD/SUB: Reg2Loc=1, ALUSrc=0, ALUOp=010 or 011 respectively; the next state SHALL be WB.
REQ-020 EXEC, ADDI/LDUR/STUR: ALUSrc=1, ALUOp=010, and Reg2Loc=0 for STUR; the next state SHALL be WB for ADDI and MEM otherwise.
REQ-021 EXEC, CBZ/CBNZ: Reg2Loc=0, ALUOp=000, PCWrite=1, UncondBr=0, BrTaken=zero for CBZ and BrTaken=~zero for CBNZ; the next state SHALL be FETCH.
REQ-022 MEM: MemRead=1 for LDUR or MemWrite=1 for STUR, held every cycle until mem_ready=1.
- LDUR with mem_ready: the next state SHALL be WB.
- STUR with mem_ready: PCWrite=1 that cycle, and the next state SHALL be FETCH.
REQ-023 A MEM wait counter SHALL clear on entry to MEM and increment each cycle in MEM without mem_ready.
- If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT with mem_ready=0, the next state SHALL be TRAP and mem_err SHALL set.
- If mem_ready=1 on the timeout cycle, completion SHALL win.
REQ-024 WB: RegWrite=1, PCWrite=1, and MemToReg=1 for LDUR only; the next state SHALL be FETCH.
REQ-025 TRAP: trap=1 and all other control outputs 0; the FSM SHALL remain in TRAP until reset.
REQ-026 retired SHALL increment on every cycle with PCWrite=1, saturate at all-ones, and never wrap.
REQ-027 Latency in cycles from FETCH to the next FETCH SHALL be:
- B: 2
- CBZ/CBNZ: 3
- ADD/SUB/ADDI: 4
- STUR: 4+w
- LDUR: 5+w
where w is the number of mem_ready=0 cycles in MEM.

Reset
REQ-028 While reset_n=0 at a rising edge, the state SHALL become FETCH and the latched class, the wait counter, retired, trap and mem_err SHALL clear.
REQ-029 During the reset cycle all outputs SHALL be 0; FETCH outputs begin on the first cycle after reset_n=1.
REQ-030 Reset asserted in any state, including MEM mid-wait or TRAP, SHALL abort the operation; no further MemRead, MemWrite or RegWrite SHALL occur after that edge.

Verification
REQ-031 instr=0x8B000000 (ADD): the bench SHALL see IRWrite, then DECODE, then ALUOp=010 and Reg2Loc=1, then RegWrite=1 and PCWrite=1, 4 cycles in total, with retired=1.
REQ-032 instr=0xF8400000 (LDUR), mem_ready low 3 cycles: the bench SHALL see MemRead held 4 cycles, then WB with MemToReg=1, 8 cycles in total.
REQ-033 CBZ 0xB4000000 with zero=1 SHALL give BrTaken=1; CBNZ 0xB5000000 with zero=1 SHALL give BrTaken=0; with EN_CBNZ=0, 0xB5000000 SHALL give trap=1.
REQ-034 STUR 0xF8000000 with mem_ready stuck 0 and MEM_TIMEOUT=15 SHALL reach TRAP with mem_err=1 after 15 MEM cycles; mem_ready=1 exactly on cycle 15 SHALL complete normally.
REQ-035 instr=0x00000000 SHALL give TRAP after DECODE; a subsequent reset_n=0 for one cycle SHALL return the FSM to FETCH with trap=0.
REQ-036 With CNT_W=2, 5 B instructions (0x14000000) SHALL leave retired=3.
